mips_multicycle_ctrl: RTL and testbench

- Multicycle MIPS controller: a Moore FSM sequencing fetch, decode, execute, memory and writeback over 3-5 cycles per instruction.
- Drives the ALU control interface (alu_control encoding: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT) and consumes the ALU zero flag.
- Also generates datapath strobes and mux selects for a shared-memory multicycle datapath.

---
 rtl/mips_multicycle_ctrl_if.sv | 29 ++
 rtl/mips_multicycle_ctrl.sv | 151 +++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: controller <-> datapath bundle; master is the datapath side, slave the controller.
interface mips_multicycle_ctrl_if #(parameter int STATE_W = 4);
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               zero;
    logic [2:0]         alu_control;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         pc_src;
    logic               iord;
    logic               mem_write;
    logic               ir_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic               pc_en;
    logic               illegal_op;
    logic [STATE_W-1:0] dbg_state;
    modport master (
        output opcode, funct, zero,
        input  alu_control, alu_src_a, alu_src_b, pc_src, iord, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, pc_en, illegal_op, dbg_state
    );
    modport slave (
        input  opcode, funct, zero,
        output alu_control, alu_src_a, alu_src_b, pc_src, iord, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, pc_en, illegal_op, dbg_state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS Moore controller for a shared-memory datapath.
// Optional bne support is enabled by defining MIPS_CTRL_BNE_EN.
module mips_multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input logic                   clk,
    input logic                   reset,
    mips_multicycle_ctrl_if.slave ctrl_if
);
    localparam logic [STATE_W-1:0] FETCH   = STATE_W'(0);
    localparam logic [STATE_W-1:0] DECODE  = STATE_W'(1);
    localparam logic [STATE_W-1:0] MEMADR  = STATE_W'(2);
    localparam logic [STATE_W-1:0] MEMRD   = STATE_W'(3);
    localparam logic [STATE_W-1:0] MEMWB   = STATE_W'(4);
    localparam logic [STATE_W-1:0] MEMWR   = STATE_W'(5);
    localparam logic [STATE_W-1:0] RTYPEEX = STATE_W'(6);
    localparam logic [STATE_W-1:0] RTYPEWB = STATE_W'(7);
    localparam logic [STATE_W-1:0] BEQEX   = STATE_W'(8);
    localparam logic [STATE_W-1:0] ADDIEX  = STATE_W'(9);
    localparam logic [STATE_W-1:0] ADDIWB  = STATE_W'(10);
    localparam logic [STATE_W-1:0] JEX     = STATE_W'(11);
`ifdef MIPS_CTRL_BNE_EN
    localparam logic [STATE_W-1:0] BNEEX   = STATE_W'(12);
    localparam logic [5:0]         OP_BNE  = 6'b000101;
`endif
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic [STATE_W-1:0] state_q, state_d, st;
    logic               funct_ok, pc_write, branch;
    logic               mem_write, ir_write, reg_write;
    logic [2:0]         alu_r;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    assign funct_ok = ctrl_if.funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    assign alu_r = ctrl_if.funct == 6'b100010 ? 3'b110 :
                   ctrl_if.funct == 6'b100100 ? 3'b000 :
                   ctrl_if.funct == 6'b100101 ? 3'b001 :
                   ctrl_if.funct == 6'b101010 ? 3'b111 : 3'b010;

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE:
                case (ctrl_if.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:       state_d = BNEEX;
`endif
                    default:      state_d = FETCH;
                endcase
            MEMADR:  state_d = ctrl_if.opcode == OP_SW ? MEMWR : MEMRD;
            MEMRD:   state_d = MEMWB;
            RTYPEEX: state_d = funct_ok ? RTYPEWB : FETCH;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // Reset presents FETCH mux selects; strobes are gated separately below.
    assign st = reset ? FETCH : state_q;

    always_comb begin
        ctrl_if.alu_control = 3'b000;
        ctrl_if.alu_src_a   = 1'b0;
        ctrl_if.alu_src_b   = 2'b00;
        ctrl_if.pc_src      = 2'b00;
        ctrl_if.iord        = 1'b0;
        ctrl_if.reg_dst     = 1'b0;
        ctrl_if.mem_to_reg  = 1'b0;
        mem_write           = 1'b0;
        ir_write            = 1'b0;
        reg_write           = 1'b0;
        pc_write            = 1'b0;
        branch              = 1'b0;
        case (st)
            FETCH: begin
                ir_write            = 1'b1;
                ctrl_if.alu_src_b   = 2'b01;
                ctrl_if.alu_control = 3'b010;
                pc_write            = 1'b1;
            end
            DECODE: begin
                ctrl_if.alu_src_b   = 2'b11;
                ctrl_if.alu_control = 3'b010;
            end
            MEMADR, ADDIEX: begin
                ctrl_if.alu_src_a   = 1'b1;
                ctrl_if.alu_src_b   = 2'b10;
                ctrl_if.alu_control = 3'b010;
            end
            MEMRD: ctrl_if.iord = 1'b1;
            MEMWB: begin
                ctrl_if.mem_to_reg = 1'b1;
                reg_write          = 1'b1;
            end
            MEMWR: begin
                ctrl_if.iord = 1'b1;
                mem_write    = 1'b1;
            end
            RTYPEEX: begin
                ctrl_if.alu_src_a   = 1'b1;
                ctrl_if.alu_control = alu_r;
            end
            RTYPEWB: begin
                ctrl_if.reg_dst = 1'b1;
                reg_write       = 1'b1;
            end
`ifdef MIPS_CTRL_BNE_EN
            BEQEX, BNEEX: begin
`else
            BEQEX: begin
`endif
                ctrl_if.alu_src_a   = 1'b1;
                ctrl_if.alu_control = 3'b110;
                ctrl_if.pc_src      = 2'b01;
                branch              = 1'b1;
            end
            ADDIWB: reg_write = 1'b1;
            JEX: begin
                ctrl_if.pc_src = 2'b10;
                pc_write       = 1'b1;
            end
            default: ;
        endcase
    end

    assign ctrl_if.mem_write  = mem_write & ~reset;
    assign ctrl_if.ir_write   = ir_write & ~reset;
    assign ctrl_if.reg_write  = reg_write & ~reset;
    assign ctrl_if.illegal_op = ~reset & (state_q == DECODE || state_q == RTYPEEX) && state_d == FETCH;
`ifdef MIPS_CTRL_BNE_EN
    assign ctrl_if.pc_en = ~reset & (pc_write | (branch & (st == BNEEX ? ~ctrl_if.zero : ctrl_if.zero)));
`else
    assign ctrl_if.pc_en = ~reset & (pc_write | (branch & ctrl_if.zero));
`endif
    assign ctrl_if.dbg_state = state_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed plus randomized instruction streams checked against a per-instruction trace model.
module tb_mips_multicycle_ctrl;
    typedef int q_t[$];
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    mips_multicycle_ctrl_if #(.STATE_W(4)) ifc ();
    mips_multicycle_ctrl #(.STATE_W(4)) dut (.clk(clk), .reset(reset), .ctrl_if(ifc));

    always #5 clk = ~clk;

    function automatic bit legal_op(input logic [5:0] op);
`ifdef MIPS_CTRL_BNE_EN
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000101};
`else
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
`endif
    endfunction

    function automatic bit legal_fn(input logic [5:0] fn);
        return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    function automatic logic [2:0] falu(input logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // State sequence an instruction walks through, starting at FETCH.
    function automatic q_t trace(input logic [5:0] op, input logic [5:0] fn);
        q_t q;
        q = '{0, 1};
        if (!legal_op(op)) return q;
        case (op)
            6'b100011: q = '{0, 1, 2, 3, 4};
            6'b101011: q = '{0, 1, 2, 5};
            6'b000000: q = legal_fn(fn) ? '{0, 1, 6, 7} : '{0, 1, 6};
            6'b000100: q = '{0, 1, 8};
            6'b001000: q = '{0, 1, 9, 10};
            6'b000010: q = '{0, 1, 11};
            default:   q = '{0, 1, 12};
        endcase
        return q;
    endfunction

    // {alu_control, alu_src_a, alu_src_b, pc_src, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, pc_en, illegal_op}
    function automatic logic [15:0] exp_out(input int s, input logic [5:0] op, input logic [5:0] fn, input logic z);
        logic [2:0] alu = 3'b000;
        logic [1:0] b = 2'b00, pcs = 2'b00;
        logic a = 0, io = 0, mw = 0, ir = 0, rd = 0, m2r = 0, rw = 0, pe = 0, ill = 0;
        case (s)
            0:     begin ir = 1; b = 2'b01; alu = 3'b010; pe = 1; end
            1:     begin b = 2'b11; alu = 3'b010; ill = !legal_op(op); end
            2, 9:  begin a = 1; b = 2'b10; alu = 3'b010; end
            3:     io = 1;
            4:     begin m2r = 1; rw = 1; end
            5:     begin io = 1; mw = 1; end
            6:     begin a = 1; alu = falu(fn); ill = !legal_fn(fn); end
            7:     begin rd = 1; rw = 1; end
            8, 12: begin a = 1; alu = 3'b110; pcs = 2'b01; pe = (s == 8) ? z : !z; end
            10:    rw = 1;
            11:    begin pcs = 2'b10; pe = 1; end
            default: ;
        endcase
        return {alu, a, b, pcs, io, mw, ir, rd, m2r, rw, pe, ill};
    endfunction

    function automatic logic [15:0] obs();
        return {ifc.alu_control, ifc.alu_src_a, ifc.alu_src_b, ifc.pc_src, ifc.iord, ifc.mem_write,
                ifc.ir_write, ifc.reg_dst, ifc.mem_to_reg, ifc.reg_write, ifc.pc_en, ifc.illegal_op};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int s, input logic [5:0] op, input logic [5:0] fn, input int zm);
        ifc.zero = (zm == 2) ? 1'($urandom_range(0, 1)) : 1'(zm);
        @(negedge clk);
        chk($sformatf("state op=%b", op), 16'(ifc.dbg_state), 16'(s));
        chk($sformatf("outs op=%b fn=%b st=%0d z=%b", op, fn, s, ifc.zero), obs(), exp_out(s, op, fn, ifc.zero));
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zm);
        q_t q;
        ifc.opcode = op;
        ifc.funct  = fn;
        q = trace(op, fn);
        foreach (q[i]) step(q[i], op, fn, zm);
    endtask

    localparam logic [15:0] RST_MASK = 16'hFFDD;
    logic [5:0] ops[7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000101};
    logic [5:0] fns[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    initial begin
        logic [5:0] op, fn;
        int k;
        reset = 1'b1;
        ifc.opcode = 6'b100011;
        ifc.funct = 6'b000000;
        ifc.zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", 16'(ifc.dbg_state), 16'd0);
        chk("reset outs", obs(), exp_out(0, 6'b0, 6'b0, 1'b0) & RST_MASK);
        reset = 1'b0;
        run_instr(6'b100011, 6'b000000, 2);
        run_instr(6'b000000, 6'b100010, 2);
        run_instr(6'b000000, 6'b101010, 2);
        run_instr(6'b000000, 6'b000000, 2);
        run_instr(6'b000100, 6'b000000, 1);
        run_instr(6'b000100, 6'b000000, 0);
        run_instr(6'b000010, 6'b000000, 2);
        run_instr(6'b101011, 6'b000000, 2);
        run_instr(6'b001000, 6'b000000, 2);
        run_instr(6'b000101, 6'b000000, 0);
        run_instr(6'b000101, 6'b000000, 1);
        run_instr(6'b111111, 6'b000000, 2);
        // lw aborted by reset while in MEMRD
        ifc.opcode = 6'b100011;
        step(0, 6'b100011, 6'b0, 2);
        step(1, 6'b100011, 6'b0, 2);
        step(2, 6'b100011, 6'b0, 2);
        reset = 1'b1;
        @(negedge clk);
        chk("reset in MEMRD state", 16'(ifc.dbg_state), 16'd3);
        chk("reset in MEMRD outs", obs(), exp_out(0, 6'b0, 6'b0, 1'b0) & RST_MASK);
        @(posedge clk);
        #1;
        chk("after abort state", 16'(ifc.dbg_state), 16'd0);
        chk("after abort outs", obs(), exp_out(0, 6'b0, 6'b0, 1'b0) & RST_MASK);
        reset = 1'b0;
        for (int n = 0; n < 120; n++) begin
            k  = int'($urandom_range(0, 7));
            op = (k == 7) ? 6'($urandom) : ops[k];
            k  = int'($urandom_range(0, 5));
            fn = (k == 5) ? 6'($urandom) : fns[k];
            run_instr(op, fn, 2);
        end
        @(negedge clk);
        chk("final state", 16'(ifc.dbg_state), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
